// File: rtl/i2f32_issue_if.sv
// rtl/i2f32_issue_if.sv - request, converter and result signal bundle for i2f32_issue
interface i2f32_issue_if #(
  parameter int FPWID = 32,
  parameter int TAGW  = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [2:0]       req_rm;
  logic [FPWID-1:0] req_i;
  logic [TAGW-1:0]  req_tag;
  logic             cvt_ce;
  logic             cvt_op;
  logic [2:0]       cvt_rm;
  logic [FPWID-1:0] cvt_i;
  logic [FPWID-1:0] cvt_o;
  logic             res_valid;
  logic             res_ready;
  logic [FPWID-1:0] res_o;
  logic [TAGW-1:0]  res_tag;
  logic             res_nx;

  modport slave (
    input  req_valid, req_op, req_rm, req_i, req_tag, cvt_o, res_ready,
    output req_ready, cvt_ce, cvt_op, cvt_rm, cvt_i, res_valid, res_o, res_tag, res_nx
  );

  modport master (
    output req_valid, req_op, req_rm, req_i, req_tag, cvt_o, res_ready,
    input  req_ready, cvt_ce, cvt_op, cvt_rm, cvt_i, res_valid, res_o, res_tag, res_nx
  );
endinterface

// File: rtl/i2f32_issue.sv
// rtl/i2f32_issue.sv - request FIFO, credit-gated issue and result buffer for the i2f converter; I2F_ISSUE_NX_EN enables res_nx
module i2f32_issue #(
  parameter int FPWID = 32,
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input logic          clk,
  input logic          rst_n,
  i2f32_issue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             q_op  [DEPTH];
  logic [2:0]       q_rm  [DEPTH];
  logic [FPWID-1:0] q_i   [DEPTH];
  logic [TAGW-1:0]  q_tag [DEPTH];
  logic [AW-1:0]    head;
  logic             ready_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             issue;
  logic             inflight;
  logic [2:0]       load;
  logic [2:0]       limit;
  logic [TAGW-1:0]  side_tag;
  logic [1:0]       ocount;
  logic             ob_wr;
  logic             ob_rd;
  logic [FPWID-1:0] ob_o   [2];
  logic [TAGW-1:0]  ob_tag [2];
  logic             ob_nx  [2];
  logic             has_res;
  logic             cap_nx;

  assign head       = rd_ptr[AW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // ready_en keeps req_ready low until the first edge after reset release
  assign bus.req_ready = ready_en & ~fifo_full;
  assign push          = bus.req_valid & ready_en & ~fifo_full;
  assign has_res       = (ocount != 2'd0);
  assign pop           = has_res & bus.res_ready;

  // Buffered plus in-flight results, less the one leaving now, must leave a free slot
  assign load  = {1'b0, ocount} + {2'b00, inflight};
  assign limit = 3'd2 + {2'b00, pop};
  assign issue = ~fifo_empty & (load < limit);

  // Converter operands follow the FIFO head; zero when nothing is queued
  always_comb begin
    bus.cvt_ce = issue;
    bus.cvt_op = 1'b0;
    bus.cvt_rm = 3'd0;
    bus.cvt_i  = '0;
    if (!fifo_empty) begin
      bus.cvt_op = q_op[head];
      bus.cvt_rm = q_rm[head];
      bus.cvt_i  = q_i[head];
    end
  end

  // Request-side control: ready gate, FIFO pointers, in-flight flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      inflight <= issue;
    end
  end

  // Queue storage and the side register that carries the issued tag to capture
  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr[AW-1:0]]  <= bus.req_op;
      q_rm[wr_ptr[AW-1:0]]  <= bus.req_rm;
      q_i[wr_ptr[AW-1:0]]   <= bus.req_i;
      q_tag[wr_ptr[AW-1:0]] <= bus.req_tag;
    end
    if (issue) side_tag <= q_tag[head];
  end

`ifdef I2F_ISSUE_NX_EN
  logic             side_op;
  logic [FPWID-1:0] side_i;
  logic [FPWID-1:0] mag;
  logic [7:0]       lead_idx;
  logic [7:0]       low_idx;

  // Operand copy used only to derive the inexact flag at capture
  always_ff @(posedge clk) begin
    if (issue) begin
      side_op <= q_op[head];
      side_i  <= q_i[head];
    end
  end

  // Inexact when the set bits of the magnitude span more than the 24-bit significand
  always_comb begin
    mag      = (side_op & side_i[FPWID-1]) ? -side_i : side_i;
    lead_idx = 8'd0;
    low_idx  = 8'd0;
    for (int k = 0; k < FPWID; k++)
      if (mag[k]) lead_idx = 8'(k);
    for (int k = FPWID - 1; k >= 0; k--)
      if (mag[k]) low_idx = 8'(k);
    cap_nx = (mag != '0) && ((lead_idx - low_idx) >= 8'd24);
  end
`else
  assign cap_nx = 1'b0;
`endif

  // Output buffer pointers and occupancy; capture and pop together leave ocount unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocount <= 2'd0;
      ob_wr  <= 1'b0;
      ob_rd  <= 1'b0;
    end else begin
      if (inflight) ob_wr <= ~ob_wr;
      if (pop)      ob_rd <= ~ob_rd;
      case ({inflight, pop})
        2'b10:   ocount <= ocount + 2'd1;
        2'b01:   ocount <= ocount - 2'd1;
        default: ocount <= ocount;
      endcase
    end
  end

  // Capture the converter result with its tag one cycle after issue
  always_ff @(posedge clk) begin
    if (inflight) begin
      ob_o[ob_wr]   <= bus.cvt_o;
      ob_tag[ob_wr] <= side_tag;
      ob_nx[ob_wr]  <= cap_nx;
    end
  end

  assign bus.res_valid = has_res;
  assign bus.res_o     = has_res ? ob_o[ob_rd]   : '0;
  assign bus.res_tag   = has_res ? ob_tag[ob_rd] : '0;
  assign bus.res_nx    = has_res ? ob_nx[ob_rd]  : 1'b0;
endmodule

// File: tb/tb_i2f32_issue.sv
// tb/tb_i2f32_issue.sv - randomized scoreboard bench for i2f32_issue
module tb_i2f32_issue;
  localparam int FPWID = 32;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
`ifdef I2F_ISSUE_NX_EN
  localparam bit NX_ON = 1'b1;
`else
  localparam bit NX_ON = 1'b0;
`endif

  typedef struct packed {
    logic        op;
    logic [2:0]  rm;
    logic [31:0] i;
    logic [3:0]  tag;
  } req_t;

  typedef struct {
    logic        op;
    logic [2:0]  rm;
    logic [31:0] i;
    logic [3:0]  tag;
    logic [31:0] o;
    logic        nx;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  req_t pool [512];
  req_t exp_q [$];

  i2f32_issue_if #(.FPWID(FPWID), .TAGW(TAGW)) bus ();

  i2f32_issue #(.FPWID(FPWID), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference integer-to-float conversion (rm: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM)
  function automatic logic [31:0] i2f(input logic op, input logic [2:0] rm, input logic [31:0] i);
    logic        s;
    logic [31:0] m;
    logic [31:0] sh;
    logic [63:0] kept;
    logic [63:0] rem;
    logic [63:0] half;
    logic        up;
    logic [7:0]  e;
    int          p;
    s = op & i[31];
    m = s ? 32'd0 - i : i;
    if (m == 32'd0) return 32'd0;
    p = 31;
    while (!m[p]) p--;
    e = 8'(127 + p);
    if (p <= 23) begin
      sh = m << (23 - p);
      return {s, e, sh[22:0]};
    end
    kept = {32'd0, m} >> (p - 23);
    rem  = {32'd0, m} & ((64'd1 << (p - 23)) - 64'd1);
    half = 64'd1 << (p - 24);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = s && (rem != 0);
      3'd3:    up = !s && (rem != 0);
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && kept[0]);
    endcase
    kept = kept + {63'd0, up};
    if (kept[24]) begin
      kept = kept >> 1;
      e    = e + 8'd1;
    end
    return {s, e, kept[22:0]};
  endfunction

  // Inexact rule: set bits of the magnitude spread 24 or more positions apart
  function automatic logic nx_ref(input logic op, input logic [31:0] i);
    logic [31:0] m;
    int hi;
    int lo;
    if (!NX_ON) return 1'b0;
    m = (op && i[31]) ? 32'd0 - i : i;
    if (m == 32'd0) return 1'b0;
    hi = -1;
    lo = -1;
    for (int k = 0; k < 32; k++)
      if (m[k]) begin
        if (lo < 0) lo = k;
        hi = k;
      end
    return (hi - lo) >= 24;
  endfunction

  // Converter stand-in with one cycle of latency
  always @(posedge clk)
    if (bus.cvt_ce) bus.cvt_o <= i2f(bus.cvt_op, bus.cvt_rm, bus.cvt_i);

  task automatic gen_pool;
    for (int s = 0; s < 512; s++) begin
      pool[s].op  = 1'($urandom);
      pool[s].rm  = 3'($urandom_range(0, 4));
      pool[s].tag = 4'(s);
      case ($urandom_range(0, 3))
        0:       pool[s].i = $urandom;
        1:       pool[s].i = $urandom_range(0, 300);
        2:       pool[s].i = 32'd1 << $urandom_range(0, 31);
        default: pool[s].i = 32'd0 - $urandom_range(0, 300);
      endcase
    end
  endtask

  task automatic drive(input int s, input bit v);
    bus.req_valid = v;
    bus.req_op    = pool[s].op;
    bus.req_rm    = pool[s].rm;
    bus.req_i     = pool[s].i;
    bus.req_tag   = pool[s].tag;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_rm = 3'd0; bus.req_i = '0;
    bus.req_tag = '0; bus.res_ready = 1'b0; bus.cvt_o = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b required=0", bus.req_ready); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b required=0", bus.res_valid); end
    total++; if ({bus.res_o, bus.res_tag, bus.res_nx} !== '0) begin
      bad++; $display("FAIL rst_res_fields got o=%h tag=%h nx=%b required 0", bus.res_o, bus.res_tag, bus.res_nx); end
    total++; if ({bus.cvt_ce, bus.cvt_op, bus.cvt_rm, bus.cvt_i} !== '0) begin
      bad++; $display("FAIL rst_cvt got ce=%b op=%b rm=%0d i=%h required 0", bus.cvt_ce, bus.cvt_op, bus.cvt_rm, bus.cvt_i); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_pre_edge got=%b required=0", bus.req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_post_edge got=%b required=1", bus.req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    vec_t v [5];
    v[0] = '{1'b1, 3'd0, 32'h00000001, 4'd3, 32'h3F800000, 1'b0};
    v[1] = '{1'b1, 3'd0, 32'hFFFFFFFF, 4'd5, 32'hBF800000, 1'b0};
    v[2] = '{1'b1, 3'd0, 32'h00000000, 4'd6, 32'h00000000, 1'b0};
    v[3] = '{1'b0, 3'd0, 32'h01000001, 4'd7, 32'h4B800000, NX_ON};
    v[4] = '{1'b0, 3'd0, 32'h01000000, 4'd8, 32'h4B800000, 1'b0};
    bus.res_ready = 1'b1;
    foreach (v[n]) begin
      bus.req_valid = 1'b1; bus.req_op = v[n].op; bus.req_rm = v[n].rm;
      bus.req_i = v[n].i; bus.req_tag = v[n].tag;
      @(negedge clk);
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_accept got=%b required=1", n, bus.req_ready); end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      total++; if ({bus.cvt_ce, bus.cvt_i} !== {1'b1, v[n].i}) begin
        bad++; $display("FAIL dir%0d_issue got ce=%b i=%h required ce=1 i=%h", n, bus.cvt_ce, bus.cvt_i, v[n].i); end
      total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early1 got=%b required=0", n, bus.res_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early2 got=%b required=0", n, bus.res_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency got=%b required=1", n, bus.res_valid); end
      total++; if ({bus.res_o, bus.res_tag, bus.res_nx} !== {v[n].o, v[n].tag, v[n].nx}) begin
        bad++; $display("FAIL dir%0d_result got o=%h tag=%0d nx=%b required o=%h tag=%0d nx=%b",
                        n, bus.res_o, bus.res_tag, bus.res_nx, v[n].o, v[n].tag, v[n].nx); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int   seq  = 0;
    int   nres = 0;
    req_t e;
    exp_q.delete();
    bus.res_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(seq, seq < 8);
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) begin exp_q.push_back(pool[seq]); seq++; end
      @(posedge clk); #1;
    end
    total++; if (seq !== 6) begin bad++; $display("FAIL bp_accepted got=%0d required=6", seq); end
    drive(seq, 1'b0);
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b required=0", bus.req_ready); end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 40 && nres < 8; c++) begin
      drive(seq, seq < 8);
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) begin exp_q.push_back(pool[seq]); seq++; end
      if (bus.res_valid && bus.res_ready) begin
        total++;
        nres++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra got tag=%0d required none", bus.res_tag);
        end else begin
          e = exp_q.pop_front();
          if ({bus.res_o, bus.res_tag, bus.res_nx} !== {i2f(e.op, e.rm, e.i), e.tag, nx_ref(e.op, e.i)}) begin
            bad++; $display("FAIL bp_result got o=%h tag=%0d nx=%b required o=%h tag=%0d nx=%b", bus.res_o,
                            bus.res_tag, bus.res_nx, i2f(e.op, e.rm, e.i), e.tag, nx_ref(e.op, e.i));
          end
        end
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    total++; if (nres !== 8) begin bad++; $display("FAIL bp_results got=%0d required=8", nres); end
    total++; if (seq !== 8) begin bad++; $display("FAIL bp_late_accept got=%0d required=8", seq); end
  endtask

  task automatic test_back_to_back;
    int   seq    = 0;
    int   nres   = 0;
    int   first  = -1;
    int   last   = -1;
    int   stalls = 0;
    req_t e;
    exp_q.delete();
    bus.res_ready = 1'b1;
    for (int c = 0; c < 40 && nres < 16; c++) begin
      drive(seq, seq < 16);
      @(negedge clk);
      if (bus.req_valid) begin
        if (bus.req_ready) begin exp_q.push_back(pool[seq]); seq++; end
        else stalls++;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (first < 0) first = c;
        last = c;
        total++;
        nres++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got tag=%0d required none", bus.res_tag);
        end else begin
          e = exp_q.pop_front();
          if ({bus.res_o, bus.res_tag, bus.res_nx} !== {i2f(e.op, e.rm, e.i), e.tag, nx_ref(e.op, e.i)}) begin
            bad++; $display("FAIL b2b_result got o=%h tag=%0d nx=%b required o=%h tag=%0d nx=%b", bus.res_o,
                            bus.res_tag, bus.res_nx, i2f(e.op, e.rm, e.i), e.tag, nx_ref(e.op, e.i));
          end
        end
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    total++; if (stalls !== 0) begin bad++; $display("FAIL b2b_stalls got=%0d required=0", stalls); end
    total++; if (nres !== 16) begin bad++; $display("FAIL b2b_count got=%0d required=16", nres); end
    total++; if (first !== 3) begin bad++; $display("FAIL b2b_first got=%0d required=3", first); end
    total++; if (last - first !== 15) begin bad++; $display("FAIL b2b_bubbles got span=%0d required=15", last - first); end
  endtask

  task automatic test_random;
    int          seq    = 0;
    int          maxocc = 0;
    bit          held   = 1'b0;
    logic [37:0] prev   = '0;
    req_t        e;
    exp_q.delete();
    for (int c = 0; c < 330; c++) begin
      drive(seq, (c < 300) && (seq < 500) && ($urandom_range(0, 9) < 7));
      bus.res_ready = (c >= 300) || ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (held) begin
        total++;
        if ({bus.res_valid, bus.res_o, bus.res_tag, bus.res_nx} !== prev) begin
          bad++; $display("FAIL rand_stable got %h required %h", {bus.res_valid, bus.res_o, bus.res_tag, bus.res_nx}, prev);
        end
      end
      held = bus.res_valid & ~bus.res_ready;
      prev = {bus.res_valid, bus.res_o, bus.res_tag, bus.res_nx};
      if (bus.req_valid && bus.req_ready) begin exp_q.push_back(pool[seq]); seq++; end
      if (exp_q.size() > maxocc) maxocc = exp_q.size();
      if (bus.res_valid && bus.res_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_extra got tag=%0d required none", bus.res_tag);
        end else begin
          e = exp_q.pop_front();
          if ({bus.res_o, bus.res_tag, bus.res_nx} !== {i2f(e.op, e.rm, e.i), e.tag, nx_ref(e.op, e.i)}) begin
            bad++; $display("FAIL rand_result got o=%h tag=%0d nx=%b required o=%h tag=%0d nx=%b", bus.res_o,
                            bus.res_tag, bus.res_nx, i2f(e.op, e.rm, e.i), e.tag, nx_ref(e.op, e.i));
          end
        end
      end
      @(posedge clk); #1;
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rand_drain got=%0d required=0", exp_q.size()); end
    total++; if (maxocc > DEPTH + 2) begin bad++; $display("FAIL rand_occupancy got=%0d required<=%0d", maxocc, DEPTH + 2); end
  endtask

  task automatic test_reset_mid;
    int   seq   = 0;
    int   stale = 0;
    bit   got   = 1'b0;
    req_t e;
    exp_q.delete();
    bus.res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(seq, 1'b1);
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) seq++;
      @(posedge clk); #1;
    end
    drive(seq, 1'b1);
    #2;
    total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b required=1", bus.res_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rstmid_res_valid got=%b required=0", bus.res_valid); end
    total++; if ({bus.req_ready, bus.cvt_ce} !== 2'b00) begin
      bad++; $display("FAIL rstmid_ctrl got ready=%b ce=%b required 0 0", bus.req_ready, bus.cvt_ce); end
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.res_valid) stale++;
      @(posedge clk); #1;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL rstmid_stale got=%0d required=0", stale); end
    drive(10, 1'b1);
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) exp_q.push_back(pool[10]);
      if (bus.res_valid && bus.res_ready) begin
        got = 1'b1;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rstmid_extra got tag=%0d required none", bus.res_tag);
        end else begin
          e = exp_q.pop_front();
          if ({bus.res_o, bus.res_tag, bus.res_nx} !== {i2f(e.op, e.rm, e.i), e.tag, nx_ref(e.op, e.i)}) begin
            bad++; $display("FAIL rstmid_result got o=%h tag=%0d nx=%b required o=%h tag=%0d nx=%b", bus.res_o,
                            bus.res_tag, bus.res_nx, i2f(e.op, e.rm, e.i), e.tag, nx_ref(e.op, e.i));
          end
        end
      end
      @(posedge clk); #1;
      if (exp_q.size() != 0 || got) bus.req_valid = 1'b0;
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL rstmid_new got=%b required=1", got); end
  endtask

  initial begin
    gen_pool();
    test_reset();
    test_directed();
    test_backpressure();
    gen_pool();
    test_back_to_back();
    gen_pool();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish before 500000");
    $fatal(1, "watchdog expired");
  end
endmodule
